// File: rtl/seq_pkg.sv
// Shared encodings for the serializer feeding the three-ones sequence detector.
package seq_pkg;

  typedef enum logic [1:0] {
    SER_IDLE  = 2'd0,
    SER_SHIFT = 2'd1,
    SER_GAP   = 2'd2
  } ser_state_e;

  typedef enum logic [1:0] {
    NO_ONES             = 2'd0,
    ONE_ONE             = 2'd1,
    TWO_ONES            = 2'd2,
    AT_LEAST_THREE_ONES = 2'd3
  } det_state_e;

  // One counter serves both the data bits (0..width-1) and the gap cycles (0..gap-1).
  function automatic int ser_cnt_width(input int width, input int gap);
    int span;
    span = (width > gap + 1) ? width : gap + 1;
    return $clog2(span);
  endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// One-word holding register with a full flag; lets a producer queue the next word.
module ser_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             take,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             full
);

  // NOTE: the data word is cleared with the flag so an aborted word never survives a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= '0;
      full <= 1'b0;
    end else begin
      if (load) q <= d;
      // A load on the same edge as a take keeps the register full with the new word.
      if (load)      full <= 1'b1;
      else if (take) full <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder with zero-filled gaps between words and a one-word queue.
module bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int GAP       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int            CW       = ser_cnt_width(WIDTH, GAP);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_GAP = CW'((GAP > 0) ? GAP - 1 : 0);

  ser_state_e       state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_shifted, hold_q;
  logic [CW-1:0]    cnt;
  logic             hold_full, hold_load;
  logic             accept, direct_load, reload;
  logic             last_bit, last_gap, cur_bit;

  assign din_ready = rst & ~hold_full;
  assign accept    = din_valid & din_ready;
  assign hold_load = accept & ~direct_load;
  assign last_bit  = (state == SER_SHIFT) & en & (cnt == LAST_BIT);
  assign last_gap  = (state == SER_GAP) & en & (cnt == LAST_GAP);
  assign busy      = (state != SER_IDLE) | hold_full;

  assign cur_bit      = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

  ser_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk  (clk),
    .rst  (rst),
    .load (hold_load),
    .take (reload),
    .d    (din),
    .q    (hold_q),
    .full (hold_full)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= SER_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latch).
    state_nxt   = state;
    reload      = 1'b0;
    direct_load = 1'b0;
    case (state)
      SER_IDLE: begin
        if (hold_full) begin
          reload    = 1'b1;
          state_nxt = SER_SHIFT;
        end else if (accept) begin
          direct_load = 1'b1;
          state_nxt   = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (last_bit) begin
          if (GAP > 0)        state_nxt = SER_GAP;
          else if (hold_full) reload    = 1'b1;
          else                state_nxt = SER_IDLE;
        end
      end
      SER_GAP: begin
        if (last_gap) begin
          if (hold_full) begin
            reload    = 1'b1;
            state_nxt = SER_SHIFT;
          end else begin
            state_nxt = SER_IDLE;
          end
        end
      end
      default: state_nxt = SER_IDLE;
    endcase
  end

  // Shift register and shared bit/gap counter; both freeze while en is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (reload) begin
      sreg <= hold_q;
      cnt  <= '0;
    end else if (direct_load) begin
      sreg <= din;
      cnt  <= '0;
    end else if (last_bit || last_gap) begin
      cnt <= '0;
    end else if (en && state != SER_IDLE) begin
      cnt <= cnt + CW'(1);
      if (state == SER_SHIFT) sreg <= sreg_shifted;
    end
  end

  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    word_done  = 1'b0;
    case (state)
      SER_SHIFT: begin
        sout       = cur_bit;
        sout_valid = en;
        word_done  = last_bit;
      end
      SER_GAP:  sout_valid = en;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: three instances (GAP=1 MSB-first, GAP=0 MSB-first, GAP=1 LSB-first).
module tb_bit_serializer;

  localparam int NDUT = 3;
  localparam int W    = 8;

  logic                clk, rst;
  logic [NDUT-1:0]     en, din_valid, din_ready, sout, sout_valid, word_done, busy;
  logic [W-1:0]        din [NDUT];
  logic [1:0]          exp_q [NDUT][$];   // {bit, word_done} per valid serial cycle
  int                  tests_run, tests_failed;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    bit_serializer #(
      .WIDTH     (W),
      .GAP       ((g == 1) ? 0 : 1),
      .MSB_FIRST ((g == 2) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en[g]),
      .din        (din[g]),
      .din_valid  (din_valid[g]),
      .din_ready  (din_ready[g]),
      .sout       (sout[g]),
      .sout_valid (sout_valid[g]),
      .word_done  (word_done[g]),
      .busy       (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish within 400000 time units");
    $fatal(1, "timeout");
  end

  function automatic int gap_of(input int g);
    return (g == 1) ? 0 : 1;
  endfunction

  function automatic bit msb_of(input int g);
    return g != 2;
  endfunction

  // Reference: each accepted word becomes W data bits (done on the last) followed by GAP zeros.
  task automatic push_word(input int g, input logic [W-1:0] w);
    for (int i = 0; i < W; i++)
      exp_q[g].push_back({msb_of(g) ? w[W-1-i] : w[i], i == W - 1});
    for (int i = 0; i < gap_of(g); i++)
      exp_q[g].push_back(2'b00);
  endtask

  // Inputs change only at negedge+0, so sampling at +2 sees the values the next posedge uses.
  task automatic stream_monitor(input int g);
    logic [1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b1) begin
        tests_run++;
        if (sout_valid[g]) begin
          if (exp_q[g].size() == 0) begin
            tests_failed++;
            $display("FAIL stream_extra dut%0d: sout=%b word_done=%b, want no valid bit", g, sout[g], word_done[g]);
          end else begin
            e = exp_q[g].pop_front();
            if ({sout[g], word_done[g]} !== e) begin
              tests_failed++;
              $display("FAIL stream_bit dut%0d: {sout,word_done}=%b, want %b", g, {sout[g], word_done[g]}, e);
            end
          end
        end else if (word_done[g] !== 1'b0) begin
          tests_failed++;
          $display("FAIL stray_done dut%0d: word_done=%b with sout_valid=0, want 0", g, word_done[g]);
        end
        if (din_valid[g] && din_ready[g]) push_word(g, din[g]);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [4:0] got;
    din_valid = '1;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      got = {sout[g], sout_valid[g], word_done[g], busy[g], din_ready[g]};
      tests_run++;
      if (got !== 5'b0) begin
        tests_failed++;
        $display("FAIL reset_outputs dut%0d: {sout,vld,done,busy,rdy}=%b, want 00000", g, got);
      end
    end
    @(negedge clk);
    din_valid = '0;
    rst = 1'b1;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      got = {sout[g], sout_valid[g], word_done[g], busy[g], din_ready[g]};
      tests_run++;
      if (got !== 5'b00001) begin
        tests_failed++;
        $display("FAIL reset_release dut%0d: {sout,vld,done,busy,rdy}=%b, want 00001", g, got);
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_basic();
    logic [W-1:0] w;
    logic [2:0]   got, want;
    w = 8'hB4;
    @(negedge clk);
    din[0] = w;
    din_valid[0] = 1'b1;
    #1;
    tests_run++;
    if ({sout_valid[0], din_ready[0]} !== 2'b01) begin
      tests_failed++;
      $display("FAIL basic_accept: {vld,rdy}=%b, want 01", {sout_valid[0], din_ready[0]});
    end
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      din_valid[0] = 1'b0;
      #1;
      got = {sout_valid[0], sout[0], word_done[0]};
      if (i < W)       want = {1'b1, w[W-1-i], i == W - 1};
      else if (i == W) want = 3'b100;
      else             want = 3'b000;
      tests_run++;
      if (got !== want || busy[0] !== (i <= W)) begin
        tests_failed++;
        $display("FAIL basic_cycle%0d: {vld,sout,done}=%b busy=%b, want %b busy=%b", i, got, busy[0], want, i <= W);
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] w [2];
    logic         exp_s [$];
    logic [1:0]   got, want;
    w[0] = 8'hFF;
    w[1] = 8'h07;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < W; i++) exp_s.push_back(w[k][W-1-i]);
      exp_s.push_back(1'b0);
    end
    @(negedge clk);
    din[0] = w[0];
    din_valid[0] = 1'b1;
    for (int n = 1; n <= 2 * (W + 1) + 1; n++) begin
      @(negedge clk);
      if (n == 1) din[0] = w[1];
      else        din_valid[0] = 1'b0;
      #1;
      if (n <= 2) begin
        tests_run++;
        if ({din_ready[0], busy[0]} !== {n == 1, 1'b1}) begin
          tests_failed++;
          $display("FAIL b2b_hold n=%0d: {rdy,busy}=%b, want %b", n, {din_ready[0], busy[0]}, {n == 1, 1'b1});
        end
      end
      got  = {sout_valid[0], sout[0]};
      want = (n - 1 < exp_s.size()) ? {1'b1, exp_s[n-1]} : 2'b00;
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL b2b_serial n=%0d: {vld,sout}=%b, want %b", n, got, want);
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_gap0();
    logic [W-1:0] words [3];
    int           acc [3];
    int           j;
    logic         want_rdy, want_vld;
    words[0] = 8'hFF;
    words[1] = 8'h07;
    words[2] = 8'hA5;
    j = 0;
    for (int n = 0; n <= 26; n++) begin
      @(negedge clk);
      if (j < 3) begin
        din[1] = words[j];
        din_valid[1] = 1'b1;
      end else begin
        din_valid[1] = 1'b0;
      end
      #1;
      want_rdy = !((n >= 2 && n <= 8) || (n >= 10 && n <= 16));
      want_vld = (n >= 1 && n <= 3 * W);
      tests_run++;
      if ({din_ready[1], sout_valid[1]} !== {want_rdy, want_vld}) begin
        tests_failed++;
        $display("FAIL gap0_cycle n=%0d: {rdy,vld}=%b, want %b", n, {din_ready[1], sout_valid[1]}, {want_rdy, want_vld});
      end
      if (j < 3 && din_ready[1]) begin
        acc[j] = n;
        j++;
      end
    end
    tests_run++;
    if (j != 3 || acc[0] != 0 || acc[1] != 1 || acc[2] != 9) begin
      tests_failed++;
      $display("FAIL gap0_accept: %0d words at cycles %0d,%0d,%0d, want 3 at 0,1,9", j, acc[0], acc[1], acc[2]);
    end
    idle_cycles(2);
  endtask

  task automatic test_stall();
    logic [W-1:0] w;
    logic [2:0]   got, want;
    logic         stalled;
    int           bi;
    w = W'($urandom);
    @(negedge clk);
    din[0] = w;
    din_valid[0] = 1'b1;
    for (int n = 1; n <= W + 3; n++) begin
      @(negedge clk);
      din_valid[0] = 1'b0;
      stalled = (n >= 5 && n <= 7);
      en[0] = !stalled;
      #1;
      bi   = (n < 5) ? n - 1 : ((n <= 8) ? 4 : n - 4);
      want = {!stalled, w[W-1-bi], !stalled && bi == W - 1};
      got  = {sout_valid[0], sout[0], word_done[0]};
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL stall_cycle n=%0d w=%h: {vld,sout,done}=%b, want %b", n, w, got, want);
      end
    end
    en[0] = 1'b1;
    idle_cycles(3);
  endtask

  task automatic test_lsb();
    logic [W-1:0] w;
    logic [2:0]   got, want;
    w = 8'h01;
    @(negedge clk);
    din[2] = w;
    din_valid[2] = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      din_valid[2] = 1'b0;
      #1;
      got = {sout_valid[2], sout[2], word_done[2]};
      if (i < W)       want = {1'b1, w[i], i == W - 1};
      else if (i == W) want = 3'b100;
      else             want = 3'b000;
      tests_run++;
      if (got !== want) begin
        tests_failed++;
        $display("FAIL lsb_cycle%0d: {vld,sout,done}=%b, want %b", i, got, want);
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] w1, w2;
    logic [4:0]   got;
    int           seen;
    w1 = W'($urandom);
    w2 = W'($urandom);
    @(negedge clk);
    din[0] = w1;
    din_valid[0] = 1'b1;
    @(negedge clk);
    din[0] = w2;
    @(negedge clk);
    din_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    tests_run++;
    if ({sout_valid[0], busy[0], din_ready[0]} !== 3'b110) begin
      tests_failed++;
      $display("FAIL rstmid_pre: {vld,busy,rdy}=%b, want 110", {sout_valid[0], busy[0], din_ready[0]});
    end
    rst = 1'b0;
    for (int g = 0; g < NDUT; g++) exp_q[g].delete();
    #1;
    got = {sout[0], sout_valid[0], word_done[0], busy[0], din_ready[0]};
    tests_run++;
    if (got !== 5'b0) begin
      tests_failed++;
      $display("FAIL rstmid_async: {sout,vld,done,busy,rdy}=%b, want 00000", got);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    got = {sout[0], sout_valid[0], word_done[0], busy[0], din_ready[0]};
    tests_run++;
    if (got !== 5'b00001) begin
      tests_failed++;
      $display("FAIL rstmid_release: {sout,vld,done,busy,rdy}=%b, want 00001", got);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      #1;
      if (sout_valid[0] || word_done[0] || busy[0]) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("FAIL rstmid_quiet: %0d active cycles after abort, want 0", seen);
    end
  endtask

  task automatic test_random(input int k, input int nwords);
    int   sent, guard;
    logic took;
    sent  = 0;
    guard = 0;
    took  = 1'b0;
    while (sent < nwords && guard < 3000) begin
      @(negedge clk);
      guard++;
      if (took) begin
        sent++;
        din_valid[k] = 1'b0;
      end
      if (!din_valid[k] && sent < nwords && $urandom_range(0, 2) != 0) begin
        din[k] = W'($urandom);
        din_valid[k] = 1'b1;
      end
      en[k] = ($urandom_range(0, 3) != 0);
      #1;
      took = din_valid[k] && din_ready[k];
    end
    tests_run++;
    if (sent != nwords) begin
      tests_failed++;
      $display("FAIL random_accept dut%0d: %0d words accepted, want %0d", k, sent, nwords);
    end
    en[k] = 1'b1;
    din_valid[k] = 1'b0;
    guard = 0;
    while ((busy[k] !== 1'b0 || exp_q[k].size() != 0) && guard < 300) begin
      @(negedge clk);
      #3;
      guard++;
    end
    tests_run++;
    if (busy[k] !== 1'b0 || exp_q[k].size() != 0) begin
      tests_failed++;
      $display("FAIL random_drain dut%0d: busy=%b pending=%0d, want busy=0 pending=0", k, busy[k], exp_q[k].size());
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    en           = '1;
    din_valid    = '0;
    for (int g = 0; g < NDUT; g++) din[g] = '0;
    #2;
    rst = 1'b0;
    fork
      stream_monitor(0);
      stream_monitor(1);
      stream_monitor(2);
    join_none
    test_reset();
    test_basic();
    test_back_to_back();
    test_gap0();
    test_stall();
    test_lsb();
    test_reset_mid();
    for (int k = 0; k < NDUT; k++) test_random(k, 25);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
